// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding and sizing.
package arb_pkg;

    localparam int N_REQ        = 4;
    localparam int HOLD_MAX_DEF = 8;
    localparam int IDX_W        = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic [IDX_W-1:0] pos;
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest hit to ptr is the last write.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = ptr + IDX_W'(i);
            if (req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_moore.sv
// Moore round-robin arbiter: grant decoded from registered state only.
// Optional grant tenure limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_moore
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             busy
);

    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("HOLD_MAX must be at least 1");
    end

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             tenure_done;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else        cnt <= cnt_next;
    end

    // Cleared while waiting so the first grant cycle always sees zero.
    always_comb begin
        cnt_next = '0;
        if (state == ST_GRANT) cnt_next = cnt + 1'b1;
    end

    assign tenure_done = (cnt == CNT_W'(HOLD_MAX - 1));
`else
    assign tenure_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            owner <= owner_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_idx;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[owner] || tenure_done) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                ptr_next   = owner + IDX_W'(1);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state == ST_GRANT) gnt[owner] = 1'b1;
    end

    assign gnt_id = (state == ST_GRANT) ? owner : '0;
    assign busy   = (state == ST_GRANT);

endmodule
